// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO defaults and read-mode constants.
package fifo_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_ADDR_W = 3;
  localparam int FIFO_STD = 0;
  localparam int FIFO_FWFT = 1;
endpackage

// File: rtl/fifo_dp_ram.sv
// fifo_dp_ram: DEPTH x DATA_W storage, synchronous write, asynchronous read.
module fifo_dp_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with level flags, error pulses and selectable FWFT read.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AF_THRESH = 6,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = FIFO_STD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow
);
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AE_THRESH);
  localparam bit IS_FWFT = (FWFT == FIFO_FWFT);
  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rd_word, data_q;
  logic              valid_q, wr_acc, rd_acc;
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty        = wr_ptr == rd_ptr;
  assign count        = wr_ptr - rd_ptr;
  assign almost_full  = count >= AF;
  assign almost_empty = count <= AE;
  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;
  fifo_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_word)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + (ADDR_W+1)'(wr_acc);
      rd_ptr    <= rd_ptr + (ADDR_W+1)'(rd_acc);
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      valid_q   <= rd_acc;
      if (rd_acc) data_q <= rd_word;
    end
  end
  // FWFT gates the unreset memory word so data_out reads 0 while empty
  assign data_out = IS_FWFT ? (empty ? '0 : rd_word) : data_q;
  assign rd_valid = IS_FWFT ? !empty : valid_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: scoreboard-checked bench for standard and FWFT FIFO instances.
module tb_param_sync_fifo;
  logic clk = 1'b0, rst = 1'b0;
  logic wr_en = 1'b0, rd_en = 1'b0;
  logic [3:0] data_in = '0, data_out;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [3:0] count;
  logic f_wr_en = 1'b0, f_rd_en = 1'b0;
  logic [3:0] f_data_in = '0, f_data_out;
  logic f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [3:0] f_count;
  int errs = 0, checks = 0;
  logic [3:0] q[$];
  logic [3:0] last_d = '0;
  logic [3:0] d;

  always #5 clk = ~clk;

  param_sync_fifo #(.FWFT(0)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
    .data_out(data_out), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );
  param_sync_fifo #(.FWFT(1)) dut_f (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .data_in(f_data_in), .rd_en(f_rd_en),
    .data_out(f_data_out), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    int n = q.size();
    chk({tag, " count"}, 8'(count), 8'(n));
    chk({tag, " full"}, 8'(full), 8'(n == 8));
    chk({tag, " empty"}, 8'(empty), 8'(n == 0));
    chk({tag, " af"}, 8'(almost_full), 8'(n >= 6));
    chk({tag, " ae"}, 8'(almost_empty), 8'(n <= 2));
  endtask

  task automatic step(input string tag, input logic we, input logic [3:0] din, input logic re);
    bit wa, ra;
    logic [3:0] exp_d;
    wr_en = we; data_in = din; rd_en = re;
    wa = we && q.size() < 8;
    ra = re && q.size() > 0;
    exp_d = last_d;
    if (ra) exp_d = q.pop_front();
    if (wa) q.push_back(din);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    chk({tag, " ovf"}, 8'(overflow), 8'(we && !wa));
    chk({tag, " unf"}, 8'(underflow), 8'(re && !ra));
    chk({tag, " rd_valid"}, 8'(rd_valid), 8'(ra));
    chk({tag, " data_out"}, 8'(data_out), 8'(exp_d));
    chk_flags(tag);
    last_d = exp_d;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_flags("reset");
    chk("reset data_out", 8'(data_out), 8'h0);
    chk("reset rd_valid", 8'(rd_valid), 8'h0);
    chk("reset ovf", 8'(overflow), 8'h0);
    chk("reset unf", 8'(underflow), 8'h0);
    chk("reset f_rd_valid", 8'(f_rd_valid), 8'h0);
    chk("reset f_data_out", 8'(f_data_out), 8'h0);
    @(negedge clk); rst = 1'b1;
    for (int i = 1; i <= 8; i++) step("fill", 1'b1, 4'(i), 1'b0);
    step("over", 1'b1, 4'hF, 1'b0);
    step("over idle", 1'b0, 4'h0, 1'b0);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, 4'h0, 1'b1);
    step("under", 1'b0, 4'h0, 1'b1);
    step("under idle", 1'b0, 4'h0, 1'b0);
    d = 4'h9;
    for (int i = 0; i < 4; i++) begin step("fill4", 1'b1, d, 1'b0); d++; end
    for (int i = 0; i < 20; i++) begin step("stream", 1'b1, d, 1'b1); d++; end
    for (int i = 0; i < 4; i++) begin step("fill8", 1'b1, d, 1'b0); d++; end
    step("full wr+rd", 1'b1, 4'h5, 1'b1);
    for (int i = 0; i < 7; i++) step("drain7", 1'b0, 4'h0, 1'b1);
    step("empty wr+rd", 1'b1, 4'h6, 1'b1);
    step("drain1", 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 5; i++) step("pre-rst", 1'b1, 4'(i + 2), 1'b0);
    rst = 1'b0;
    #1;
    q.delete();
    last_d = '0;
    chk_flags("async rst");
    chk("async rst rd_valid", 8'(rd_valid), 8'h0);
    chk("async rst data_out", 8'(data_out), 8'h0);
    @(negedge clk); rst = 1'b1;
    step("post-rst wr", 1'b1, 4'hD, 1'b0);
    step("post-rst rd", 1'b0, 4'h0, 1'b1);
    step("post-rst idle", 1'b0, 4'h0, 1'b0);
    f_wr_en = 1'b1; f_data_in = 4'hA;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fwft valid", 8'(f_rd_valid), 8'h1);
    chk("fwft data", 8'(f_data_out), 8'hA);
    chk("fwft count", 8'(f_count), 8'h1);
    f_wr_en = 1'b1; f_data_in = 4'h3;
    @(posedge clk); #1;
    f_wr_en = 1'b0;
    chk("fwft head held", 8'(f_data_out), 8'hA);
    f_rd_en = 1'b1;
    @(posedge clk); #1;
    chk("fwft pop next", 8'(f_data_out), 8'h3);
    chk("fwft pop valid", 8'(f_rd_valid), 8'h1);
    @(posedge clk); #1;
    f_rd_en = 1'b0;
    chk("fwft empty", 8'(f_empty), 8'h1);
    chk("fwft empty valid", 8'(f_rd_valid), 8'h0);
    @(posedge clk); #1;
    chk("fwft unf", 8'(f_unf), 8'h0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
